// File: rtl/fetch_redirect_if.sv
// Fetch stage port bundle: control in, ROM side, IF->ID out.
// Slave side is the fetch stage; master side is the surrounding pipeline.
interface fetch_redirect_if;
  logic        IF_valid;
  logic        next_fetch;
  logic [32:0] jbr_bus;
  logic [32:0] exc_bus;
  logic        cancel;
  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic        IF_over;
  logic [63:0] IF_ID_bus;
  logic [31:0] IF_pc;
  logic [31:0] IF_inst;

  modport master (
    output IF_valid,
    output next_fetch,
    output jbr_bus,
    output exc_bus,
    output cancel,
    output inst,
    input  inst_addr,
    input  IF_over,
    input  IF_ID_bus,
    input  IF_pc,
    input  IF_inst
  );

  modport slave (
    input  IF_valid,
    input  next_fetch,
    input  jbr_bus,
    input  exc_bus,
    input  cancel,
    input  inst,
    output inst_addr,
    output IF_over,
    output IF_ID_bus,
    output IF_pc,
    output IF_inst
  );
endinterface

// File: rtl/fetch_redirect.sv
// Instruction fetch stage: owns the PC, drives the ROM,
// and redirects on exception, cancel and decode jumps.
module fetch_redirect #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic           clk,
  input logic           resetn,
  fetch_redirect_if.slave fi
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] pc_r;
  logic [31:0] pc_nx;
  logic [31:0] inst_r;
  logic [31:0] inst_nx;
  logic        pend_valid;
  logic        pend_valid_nx;
  logic [31:0] pend_target;
  logic [31:0] pend_target_nx;
  logic        over;

  logic        jbr_taken;
  logic [31:0] jbr_target;
  logic        exc_valid;
  logic [31:0] exc_pc;
  logic        advance;
  logic [31:0] next_pc;

  assign jbr_taken  = fi.jbr_bus[32];
  assign jbr_target = fi.jbr_bus[31:0];
  assign exc_valid  = fi.exc_bus[32];
  assign exc_pc     = fi.exc_bus[31:0];

  assign advance = (state == HOLD)
                 & fi.IF_valid
                 & fi.next_fetch
                 & ~exc_valid
                 & ~fi.cancel;

  // A latched branch outranks one arriving now.
  assign next_pc = pend_valid ? pend_target
                 : jbr_taken  ? jbr_target
                 : pc_r + 32'd4;

  always_comb begin
    state_nx       = state;
    pc_nx          = pc_r;
    inst_nx        = inst_r;
    pend_valid_nx  = pend_valid;
    pend_target_nx = pend_target;
    over           = 1'b0;
    if (exc_valid) begin
      pc_nx         = exc_pc;
      pend_valid_nx = 1'b0;
      state_nx      = IDLE;
    end else if (fi.cancel) begin
      pend_valid_nx = 1'b0;
      state_nx      = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (fi.IF_valid)
            state_nx = WAIT;
        end
        WAIT: begin
          inst_nx  = fi.inst;
          state_nx = HOLD;
        end
        HOLD: begin
          over = fi.IF_valid;
          if (advance) begin
            pc_nx         = next_pc;
            pend_valid_nx = 1'b0;
            state_nx      = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
      if (jbr_taken && !advance) begin
        pend_valid_nx  = 1'b1;
        pend_target_nx = jbr_target;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      pc_r        <= RESET_PC;
      inst_r      <= 32'd0;
      pend_valid  <= 1'b0;
      pend_target <= 32'd0;
    end else begin
      state       <= state_nx;
      pc_r        <= pc_nx;
      inst_r      <= inst_nx;
      pend_valid  <= pend_valid_nx;
      pend_target <= pend_target_nx;
    end
  end

  assign fi.inst_addr = pc_r;
  assign fi.IF_over   = over;
  assign fi.IF_ID_bus = {pc_r, inst_r};
  assign fi.IF_pc     = pc_r;
  assign fi.IF_inst   = inst_r;

endmodule
